// File: rtl/lane_traffic_sched_if.sv
// Bundle between the lane scheduler and the game logic / draw path.
// master drives the game controls, slave is the scheduler.
interface lane_traffic_sched_if #(
    parameter int c_NUM_LANES = 4
);
    logic                        i_Game_Active;
    logic                        i_Level_Up;
    logic                        i_Collision;
    logic [c_NUM_LANES*10-1:0]   o_Car_X;
    logic [c_NUM_LANES-1:0]      o_Move;
    logic [2:0]                  o_Level;
    logic                        o_Frozen;
    logic [1:0]                  o_State;

    modport master (
        output i_Game_Active, i_Level_Up, i_Collision,
        input  o_Car_X, o_Move, o_Level, o_Frozen, o_State
    );

    modport slave (
        input  i_Game_Active, i_Level_Up, i_Collision,
        output o_Car_X, o_Move, o_Level, o_Frozen, o_State
    );
endinterface

// File: rtl/lane_traffic_sched.sv
// Car lane scheduler: shared prescaler, per-lane step dividers,
// one round-robin X updater and the collision freeze/respawn sequence.
module lane_traffic_sched #(
    parameter int c_NUM_LANES    = 4,
    parameter int c_GAME_WIDTH   = 640,
    parameter int c_TICK_DIV     = 25000,
    parameter int c_BASE_DIV     = 66,
    parameter int c_LEVEL_STEP   = 8,
    parameter int c_MIN_DIV      = 10,
    parameter int c_MAX_LEVEL    = 7,
    parameter logic [c_NUM_LANES-1:0] c_DIR_MASK = 4'b1010,
    parameter logic [c_NUM_LANES*10-1:0] c_INIT_X =
        {10'd480, 10'd320, 10'd160, 10'd0},
    parameter int c_FREEZE_TICKS = 500
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    lane_traffic_sched_if.slave  bus
);

    localparam int LW = c_NUM_LANES;
    localparam int RW = $clog2(c_NUM_LANES);
    localparam int PW = $clog2(c_TICK_DIV);
    localparam int FW = $clog2(c_FREEZE_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FRZ  = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0][9:0]      car_x_q, car_x_d;
    logic [LW-1:0]           move_q, move_d;
    logic [2:0]              level_q, level_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [LW-1:0][15:0]     cnt_q, cnt_d;
    logic [FW-1:0]           frz_q, frz_d;
    logic [LW-1:0]           pend_q, pend_d;
    logic [RW-1:0]           rr_q, rr_d;

    logic                    tick;
    logic [PW-1:0]           pre_nxt;
    logic [2:0]              lvl_nxt;
    logic [15:0]             dec, div, div_m1;
    logic [RW-1:0]           sel;
    logic                    sel_v;
    logic [RW:0]             sum;
    logic [9:0]              cur_x, nxt_x;
    logic [LW-1:0]           set_v, clr_v;

    assign tick    = (state_q != S_IDLE) &&
                     (pre_q == PW'(c_TICK_DIV - 1));
    assign pre_nxt = tick ? '0 : pre_q + PW'(1);
    assign lvl_nxt = (level_q >= 3'(c_MAX_LEVEL)) ?
                     level_q : level_q + 3'd1;

    // Compare before subtracting so a high level never wraps the divider.
    always_comb begin
        dec = 16'(level_q) * 16'(c_LEVEL_STEP);
        if (dec >= 16'(c_BASE_DIV))
            div = 16'(c_MIN_DIV);
        else if (16'(c_BASE_DIV) - dec < 16'(c_MIN_DIV))
            div = 16'(c_MIN_DIV);
        else
            div = 16'(c_BASE_DIV) - dec;
        div_m1 = div - 16'd1;
    end

    always_comb begin
        sel   = '0;
        sel_v = 1'b0;
        sum   = '0;
        for (int k = 0; k < LW; k++) begin
            sum = {1'b0, rr_q} + (RW+1)'(k);
            if (sum >= (RW+1)'(LW))
                sum = sum - (RW+1)'(LW);
            if (!sel_v && pend_q[sum[RW-1:0]]) begin
                sel_v = 1'b1;
                sel   = sum[RW-1:0];
            end
        end
    end

    always_comb begin
        cur_x = car_x_q[sel];
        if (c_DIR_MASK[sel])
            nxt_x = (cur_x == 10'd0) ?
                    10'(c_GAME_WIDTH - 1) : cur_x - 10'd1;
        else
            nxt_x = (cur_x == 10'(c_GAME_WIDTH - 1)) ?
                    10'd0 : cur_x + 10'd1;
    end

    always_comb begin
        state_d = state_q;
        car_x_d = car_x_q;
        move_d  = '0;
        level_d = level_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        frz_d   = frz_q;
        pend_d  = pend_q;
        rr_d    = rr_q;
        set_v   = '0;
        clr_v   = '0;
        if (!bus.i_Game_Active) begin
            state_d = S_IDLE;
            car_x_d = c_INIT_X;
            level_d = '0;
            pre_d   = '0;
            cnt_d   = '0;
            frz_d   = '0;
            pend_d  = '0;
            rr_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    pre_d = pre_nxt;
                    if (bus.i_Level_Up)
                        level_d = lvl_nxt;
                    if (bus.i_Collision) begin
                        state_d = S_FRZ;
                        pend_d  = '0;
                    end else begin
                        if (sel_v) begin
                            car_x_d[sel] = nxt_x;
                            move_d[sel]  = 1'b1;
                            clr_v[sel]   = 1'b1;
                            if (sel == RW'(LW - 1))
                                rr_d = '0;
                            else
                                rr_d = sel + RW'(1);
                        end
                        if (tick) begin
                            for (int i = 0; i < LW; i++) begin
                                if (cnt_q[i] >= div_m1) begin
                                    cnt_d[i] = '0;
                                    set_v[i] = 1'b1;
                                end else begin
                                    cnt_d[i] = cnt_q[i] + 16'd1;
                                end
                            end
                        end
                        // A fresh tick request outranks a same-cycle service.
                        pend_d = (pend_q & ~clr_v) | set_v;
                    end
                end
                S_FRZ: begin
                    pre_d = pre_nxt;
                    if (bus.i_Level_Up)
                        level_d = lvl_nxt;
                    if (tick) begin
                        if (frz_q == FW'(c_FREEZE_TICKS - 1)) begin
                            state_d = S_RUN;
                            car_x_d = c_INIT_X;
                            cnt_d   = '0;
                            frz_d   = '0;
                        end else begin
                            frz_d = frz_q + FW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
            car_x_q <= c_INIT_X;
            move_q  <= '0;
            level_q <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            frz_q   <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            car_x_q <= car_x_d;
            move_q  <= move_d;
            level_q <= level_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            frz_q   <= frz_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.o_Car_X  = car_x_q;
    assign bus.o_Move   = move_q;
    assign bus.o_Level  = level_q;
    assign bus.o_Frozen = (state_q == S_FRZ);
    assign bus.o_State  = state_q;

endmodule

// File: tb/tb_lane_traffic_sched.sv
// Scoreboard bench for lane_traffic_sched: expected moves are queued
// by the stimulus and matched by a monitor on every o_Move pulse.
module tb_lane_traffic_sched;

    localparam logic [39:0] INITA = {10'd6, 10'd4, 10'd2, 10'd0};
    localparam logic [39:0] INITB = {10'd0, 10'd0, 10'd0, 10'd7};
    localparam logic [3:0]  DIRM  = 4'b1010;

    typedef struct {
        logic [3:0]  mv;
        logic [39:0] x;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    bit   gap_en = 1'b0;
    exp_t sbq[$];
    logic [9:0] mx[4];

    always #5 clk = ~clk;

    lane_traffic_sched_if #(.c_NUM_LANES(4)) ifa ();
    lane_traffic_sched_if #(.c_NUM_LANES(4)) ifb ();

    lane_traffic_sched #(
        .c_NUM_LANES(4), .c_GAME_WIDTH(8), .c_TICK_DIV(4),
        .c_BASE_DIV(3), .c_LEVEL_STEP(1), .c_MIN_DIV(2),
        .c_MAX_LEVEL(2), .c_DIR_MASK(DIRM), .c_INIT_X(INITA),
        .c_FREEZE_TICKS(2)
    ) dut_a (.i_Clk(clk), .i_Rst_L(rst_n), .bus(ifa));

    lane_traffic_sched #(
        .c_NUM_LANES(4), .c_GAME_WIDTH(8), .c_TICK_DIV(4),
        .c_BASE_DIV(3), .c_LEVEL_STEP(1), .c_MIN_DIV(2),
        .c_MAX_LEVEL(2), .c_DIR_MASK(DIRM), .c_INIT_X(INITB),
        .c_FREEZE_TICKS(2)
    ) dut_b (.i_Clk(clk), .i_Rst_L(rst_n), .bus(ifb));

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [9:0] step(logic [9:0] x, logic left);
        if (left) return (x == 10'd0) ? 10'd7 : x - 10'd1;
        return (x == 10'd7) ? 10'd0 : x + 10'd1;
    endfunction

    function automatic logic [39:0] packx();
        logic [39:0] p;
        for (int i = 0; i < 4; i++) p[10*i +: 10] = mx[i];
        return p;
    endfunction

    task automatic model_init();
        mx[0] = 10'd0; mx[1] = 10'd2;
        mx[2] = 10'd4; mx[3] = 10'd6;
    endtask

    task automatic push_batch();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            mx[i] = step(mx[i], DIRM[i]);
            e.mv  = 4'b0001 << i;
            e.x   = packx();
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            nclk();
            n++;
        end
        chk(nm, 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 64'(ifa.o_State), 64'd0);
        chk({tag, "_carx"}, 64'(ifa.o_Car_X), 64'(INITA));
        chk({tag, "_level"}, 64'(ifa.o_Level), 64'd0);
        chk({tag, "_move"}, 64'(ifa.o_Move), 64'd0);
        chk({tag, "_frozen"}, 64'(ifa.o_Frozen), 64'd0);
    endtask

    task automatic pulse_lvl(input logic [2:0] exp_lvl);
        @(posedge clk); #1 ifa.i_Level_Up = 1'b1;
        @(posedge clk); #1 ifa.i_Level_Up = 1'b0;
        nclk();
        chk("level_up", 64'(ifa.o_Level), 64'(exp_lvl));
    endtask

    initial begin
        int n;
        fork
            begin : monitor
                int   cyc;
                int   last;
                bit   have;
                exp_t e;
                cyc  = 0;
                last = 0;
                have = 1'b0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (ifa.o_Move != '0) begin
                        if (sbq.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_move act=%b exp=none",
                                     ifa.o_Move);
                        end else begin
                            e = sbq.pop_front();
                            chk("move_vec", 64'(ifa.o_Move), 64'(e.mv));
                            chk("move_carx", 64'(ifa.o_Car_X), 64'(e.x));
                        end
                        if (gap_en && ifa.o_Move[0]) begin
                            if (have) chk("lane0_gap", 64'(cyc - last), 64'd8);
                            last = cyc;
                            have = 1'b1;
                        end
                    end
                    if (!gap_en) have = 1'b0;
                end
            end
        join_none

        rst_n = 1'b0;
        ifa.i_Game_Active = 1'b0;
        ifa.i_Level_Up    = 1'b0;
        ifa.i_Collision   = 1'b0;
        ifb.i_Game_Active = 1'b0;
        ifb.i_Level_Up    = 1'b0;
        ifb.i_Collision   = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nclk();
        chk_reset_vals("reset");

        // Basic motion and wrap
        push_batch();
        @(posedge clk);
        #1 ifa.i_Game_Active = 1'b1;
        ifb.i_Game_Active = 1'b1;
        @(posedge clk);
        nclk();
        chk("run_entry", 64'(ifa.o_State), 64'd1);
        n = 0;
        while (ifa.o_Move == '0 && n < 40) begin
            nclk();
            n++;
        end
        chk("first_move_lat", 64'(n), 64'd13);
        drain("basic_drain", 20);
        chk("basic_x", 64'(ifa.o_Car_X),
            64'({10'd5, 10'd5, 10'd1, 10'd1}));
        chk("wrap_x", 64'(ifb.o_Car_X),
            64'({10'd7, 10'd1, 10'd7, 10'd0}));
        ifb.i_Game_Active = 1'b0;

        // Level saturation
        push_batch();
        push_batch();
        pulse_lvl(3'd1);
        pulse_lvl(3'd2);
        pulse_lvl(3'd2);
        drain("level_drain", 40);
        gap_en = 1'b1;
        push_batch();
        push_batch();
        drain("gap_drain", 40);
        gap_en = 1'b0;

        // Collision, with a second hit ignored while frozen
        @(posedge clk); #1 ifa.i_Collision = 1'b1;
        @(posedge clk); #1 ifa.i_Collision = 1'b0;
        nclk();
        chk("coll_frozen", 64'(ifa.o_Frozen), 64'd1);
        chk("coll_state", 64'(ifa.o_State), 64'd2);
        n = 0;
        while (ifa.o_State == 2'd2 && n < 30) begin
            if (n == 1) ifa.i_Collision = 1'b1;
            nclk();
            n++;
            ifa.i_Collision = 1'b0;
        end
        chk("freeze_len_ok", 64'(n >= 5 && n <= 8), 64'd1);
        chk("respawn_state", 64'(ifa.o_State), 64'd1);
        chk("respawn_frozen", 64'(ifa.o_Frozen), 64'd0);
        chk("respawn_carx", 64'(ifa.o_Car_X), 64'(INITA));
        chk("respawn_level", 64'(ifa.o_Level), 64'd2);
        model_init();
        push_batch();
        drain("respawn_drain", 30);

        // Game_Active drop at level 2
        @(posedge clk); #1 ifa.i_Game_Active = 1'b0;
        @(posedge clk);
        nclk();
        chk_reset_vals("drop");

        // Reset in the middle of FREEZE
        @(posedge clk); #1 ifa.i_Game_Active = 1'b1;
        @(posedge clk);
        nclk();
        chk("rerun_state", 64'(ifa.o_State), 64'd1);
        @(posedge clk);
        #1 ifa.i_Collision = 1'b1;
        ifa.i_Level_Up = 1'b1;
        @(posedge clk);
        #1 ifa.i_Collision = 1'b0;
        ifa.i_Level_Up = 1'b0;
        nclk();
        chk("both_state", 64'(ifa.o_State), 64'd2);
        chk("both_level", 64'(ifa.o_Level), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        ifa.i_Game_Active = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        nclk();
        chk_reset_vals("midrst");
        repeat (5) nclk();
        chk("idle_hold", 64'(ifa.o_State), 64'd0);
        model_init();
        push_batch();
        @(posedge clk); #1 ifa.i_Game_Active = 1'b1;
        @(posedge clk);
        nclk();
        chk("restart_state", 64'(ifa.o_State), 64'd1);
        drain("restart_drain", 40);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
